// File: rtl/cmap_bank.sv
// rtl/cmap_bank.sv - one palette bank: 2**PW x DW RAM, one write port, one registered read port
//  i_clk            clock
//  i_we/i_waddr/i_wdata   write port
//  i_re/i_raddr     read request; o_rdata updates only when i_re is high
//  o_rdata          registered read data (holds between reads)
module cmap_bank #(
  parameter int PW = 8,
  parameter int DW = 24
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [PW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [PW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] mem_q [2**PW];
  logic [DW-1:0] rdata_q;

  // Storage is deliberately not reset: palette contents survive i_reset.
  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
    if (i_re) rdata_q <= mem_q[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/cmap_ctrl.sv
// rtl/cmap_ctrl.sv - double-buffered false-colour palette controller with bank-copy engine
//  i_clk, i_reset                      clock, synchronous active-high reset
//  i_wr_stb/i_wr_addr/i_wr_data        host write into the shadow bank (dropped while o_busy)
//  i_swap_req                          request a bank swap at the next start-of-frame pixel
//  i_copy_req                          copy the active bank into the shadow bank
//  o_busy, o_swap_pend, o_swap_done    copy running / swap pending / swap applied pulse
//  i_pix_valid/o_pix_ready/i_pix/i_pix_last/i_pix_sof   palette-index input stream
//  o_rgb_valid/i_rgb_ready/o_r/o_g/o_b/o_rgb_last/o_rgb_sof  colour output stream
module cmap_ctrl #(
  parameter int PW = 8,
  parameter int CW = 8
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wr_stb,
  input  logic [PW-1:0]   i_wr_addr,
  input  logic [3*CW-1:0] i_wr_data,
  input  logic            i_swap_req,
  input  logic            i_copy_req,
  output logic            o_busy,
  output logic            o_swap_pend,
  output logic            o_swap_done,
  input  logic            i_pix_valid,
  output logic            o_pix_ready,
  input  logic [PW-1:0]   i_pix,
  input  logic            i_pix_last,
  input  logic            i_pix_sof,
  output logic            o_rgb_valid,
  input  logic            i_rgb_ready,
  output logic [CW-1:0]   o_r,
  output logic [CW-1:0]   o_g,
  output logic [CW-1:0]   o_b,
  output logic            o_rgb_last,
  output logic            o_rgb_sof
);

  localparam int DW = 3 * CW;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_COPY = 1'b1;
  localparam logic [PW:0] IDX_ONE = {{PW{1'b0}}, 1'b1};

  logic          state_q, state_d;
  logic          active_q, active_d;
  logic          swap_pend_q, swap_pend_d, swap_done_q, swap_done_d;
  logic          s1_valid_q, s1_valid_d, s1_last_q, s1_last_d, s1_sof_q, s1_sof_d;
  logic          s1_bank_q, s1_bank_d;
  logic [PW-1:0] s1_pix_q, s1_pix_d;
  logic          rgb_valid_q, rgb_valid_d, rgb_last_q, rgb_last_d, rgb_sof_q, rgb_sof_d;
  logic          s2_bank_q, s2_bank_d;
  logic [PW:0]   idx_q, idx_d;  // extra MSB marks "all entries already granted"
  logic          cp_wr_q, cp_wr_d;
  logic [PW-1:0] cp_idx_q, cp_idx_d;

  logic          ce, busy, copy_gnt, swap_apply, copy_done;
  logic [1:0]    bank_we, bank_re;
  logic [PW-1:0] waddr, raddr;
  logic [DW-1:0] wdata, rgb;
  logic [DW-1:0] rdata [2];

  assign ce          = !rgb_valid_q || i_rgb_ready;
  assign o_pix_ready = ce;
  assign swap_apply  = ce && i_pix_valid && i_pix_sof && swap_pend_q && (state_q != ST_COPY);
  assign copy_done   = cp_wr_q && (cp_idx_q == {PW{1'b1}});

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_copy_req && !swap_pend_q) state_d = ST_COPY;
      default: if (copy_done) state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: the copy engine only borrows the read port on a pipeline bubble
  // that is actually advancing, so pixel lookups and a stalled output are untouched.
  always_comb begin
    busy     = (state_q == ST_COPY);
    copy_gnt = busy && ce && !s1_valid_q && !idx_q[PW];
  end

  always_comb begin
    active_d    = active_q ^ swap_apply;
    swap_pend_d = swap_pend_q;
    if (swap_apply) swap_pend_d = 1'b0;
    // A fresh request wins over the clear so it waits for the following SOF.
    if (i_swap_req) swap_pend_d = 1'b1;
    swap_done_d = swap_apply;

    s1_valid_d = s1_valid_q;
    s1_pix_d   = s1_pix_q;
    s1_last_d  = s1_last_q;
    s1_sof_d   = s1_sof_q;
    s1_bank_d  = s1_bank_q;
    rgb_valid_d = rgb_valid_q;
    rgb_last_d  = rgb_last_q;
    rgb_sof_d   = rgb_sof_q;
    s2_bank_d   = s2_bank_q;
    if (ce) begin
      s1_valid_d  = i_pix_valid;
      s1_pix_d    = i_pix;
      s1_last_d   = i_pix_last;
      s1_sof_d    = i_pix_sof;
      s1_bank_d   = active_d;  // the SOF pixel that triggers a swap already uses the new bank
      rgb_valid_d = s1_valid_q;
      rgb_last_d  = s1_valid_q && s1_last_q;
      rgb_sof_d   = s1_valid_q && s1_sof_q;
      s2_bank_d   = s1_bank_q;
    end

    idx_d = idx_q;
    if (state_q == ST_IDLE) idx_d = '0;
    else if (copy_gnt)      idx_d = idx_q + IDX_ONE;
    cp_wr_d  = copy_gnt;
    cp_idx_d = idx_q[PW-1:0];
  end

  // Bank port steering: only the shadow bank is ever written.
  always_comb begin
    raddr   = copy_gnt ? idx_q[PW-1:0] : s1_pix_q;
    bank_re = '0;
    if (ce && s1_valid_q) bank_re[s1_bank_q] = 1'b1;
    if (copy_gnt)         bank_re[active_q]  = 1'b1;
    bank_we = '0;
    waddr   = i_wr_addr;
    wdata   = i_wr_data;
    if (cp_wr_q) begin
      bank_we[~active_q] = 1'b1;
      waddr = cp_idx_q;
      wdata = rdata[active_q];
    end else if (i_wr_stb && !busy) begin
      bank_we[~active_q] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      active_q    <= 1'b0;
      swap_pend_q <= 1'b0;
      swap_done_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_pix_q    <= '0;
      s1_last_q   <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_bank_q   <= 1'b0;
      rgb_valid_q <= 1'b0;
      rgb_last_q  <= 1'b0;
      rgb_sof_q   <= 1'b0;
      s2_bank_q   <= 1'b0;
      idx_q       <= '0;
      cp_wr_q     <= 1'b0;
      cp_idx_q    <= '0;
    end else begin
      active_q    <= active_d;
      swap_pend_q <= swap_pend_d;
      swap_done_q <= swap_done_d;
      s1_valid_q  <= s1_valid_d;
      s1_pix_q    <= s1_pix_d;
      s1_last_q   <= s1_last_d;
      s1_sof_q    <= s1_sof_d;
      s1_bank_q   <= s1_bank_d;
      rgb_valid_q <= rgb_valid_d;
      rgb_last_q  <= rgb_last_d;
      rgb_sof_q   <= rgb_sof_d;
      s2_bank_q   <= s2_bank_d;
      idx_q       <= idx_d;
      cp_wr_q     <= cp_wr_d;
      cp_idx_q    <= cp_idx_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    cmap_bank #(.PW(PW), .DW(DW)) u_bank (
      .i_clk   (i_clk),
      .i_we    (bank_we[b]),
      .i_waddr (waddr),
      .i_wdata (wdata),
      .i_re    (bank_re[b]),
      .i_raddr (raddr),
      .o_rdata (rdata[b])
    );
  end

  // The bank read registers are the stage-2 colour registers; they are not reset,
  // so the colour is forced to zero whenever no valid pixel is presented.
  assign rgb = rgb_valid_q ? rdata[s2_bank_q] : '0;
  assign o_r = rgb[DW-1 -: CW];
  assign o_g = rgb[DW-CW-1 -: CW];
  assign o_b = rgb[CW-1:0];

  assign o_rgb_valid = rgb_valid_q;
  assign o_rgb_last  = rgb_last_q;
  assign o_rgb_sof   = rgb_sof_q;
  assign o_busy      = busy;
  assign o_swap_pend = swap_pend_q;
  assign o_swap_done = swap_done_q;

endmodule

// File: tb/tb_cmap_ctrl.sv
// tb/tb_cmap_ctrl.sv - self-checking bench for cmap_ctrl
module tb_cmap_ctrl;

  localparam int N = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wr_stb, swap_req, copy_req, busy, swap_pend, swap_done;
  logic [7:0]  wr_addr;
  logic [23:0] wr_data;
  logic        pix_valid, pix_ready, pix_last, pix_sof;
  logic [7:0]  pix;
  logic        rgb_valid, rgb_ready, rgb_last, rgb_sof;
  logic [7:0]  r, g, b;

  cmap_ctrl #(.PW(8), .CW(8)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_wr_stb(wr_stb), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_swap_req(swap_req), .i_copy_req(copy_req),
    .o_busy(busy), .o_swap_pend(swap_pend), .o_swap_done(swap_done),
    .i_pix_valid(pix_valid), .o_pix_ready(pix_ready), .i_pix(pix),
    .i_pix_last(pix_last), .i_pix_sof(pix_sof),
    .o_rgb_valid(rgb_valid), .i_rgb_ready(rgb_ready),
    .o_r(r), .o_g(g), .o_b(b), .o_rgb_last(rgb_last), .o_rgb_sof(rgb_sof)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;

  // Reference model: two palettes, which one is active, pending swap, copy running.
  logic [23:0] mbank [2][N];
  logic        mact = 1'b0, mpend = 1'b0, mdone = 1'b0, mbusy = 1'b0;

  typedef struct { logic [23:0] rgb; logic last; logic sof; int t; } exp_t;
  exp_t expq[$];

  bit          lat_chk = 1'b0;
  bit          use_tbl = 1'b0;
  logic [23:0] tbl_rgb = '0;
  bit          acc = 1'b0;

  typedef struct { logic [7:0] pix; logic sof; logic last; logic swap; logic [23:0] rgb; } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model by the
  // transfers that the coming rising edge performs, then step past the edge.
  task automatic tick();
    exp_t e;
    logic new_busy, started;
    started = 1'b0;
    @(negedge clk);
    acc = pix_valid && pix_ready;
    if (!rst) begin
      chk("swap_pend", swap_pend, mpend);
      chk("swap_done", swap_done, mdone);
      if (swap_done) done_cnt++;
      if (rgb_valid && rgb_ready) begin
        if (expq.size() == 0) chk("unexpected_pixel", 1, 0);
        else begin
          e = expq.pop_front();
          chk("rgb", {r, g, b}, e.rgb);
          chk("rgb_last", rgb_last, e.last);
          chk("rgb_sof", rgb_sof, e.sof);
          if (lat_chk) chk("latency", cyc - e.t, 2);
        end
      end
    end
    if (rst) begin
      mact = 1'b0; mpend = 1'b0; mdone = 1'b0; mbusy = 1'b0;
      expq.delete();
    end else begin
      if (wr_stb && !mbusy) mbank[!mact][wr_addr] = wr_data;
      new_busy = mbusy;
      if (copy_req && !mbusy && !mpend) begin new_busy = 1'b1; started = 1'b1; end
      mdone = 1'b0;
      if (acc) begin
        if (pix_sof && mpend && !mbusy) begin mact = !mact; mpend = 1'b0; mdone = 1'b1; end
        e.rgb  = use_tbl ? tbl_rgb : mbank[mact][pix];
        e.last = pix_last;
        e.sof  = pix_sof;
        e.t    = cyc;
        expq.push_back(e);
      end
      if (swap_req) mpend = 1'b1;
      mbusy = new_busy;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (started) chk("busy_start", busy, 1);
    else if (!rst && mbusy && !busy) begin
      // copy finished: shadow now mirrors the active palette
      mbusy = 1'b0;
      for (int i = 0; i < N; i++) mbank[!mact][i] = mbank[mact][i];
    end
  endtask

  task automatic drain();
    pix_valid = 1'b0; pix_sof = 1'b0; pix_last = 1'b0; rgb_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic fill_shadow(input int kind);
    for (int p = 0; p < N; p++) begin
      wr_stb = 1'b1; wr_addr = 8'(p);
      case (kind)
        0:       wr_data = {8'(p), 8'(p), 8'(p)};
        1:       wr_data = 24'($urandom);
        default: wr_data = {~8'(p), 8'(p), ~8'(p)};
      endcase
      tick();
    end
    wr_stb = 1'b0;
  endtask

  task automatic swap_now();
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    pix_valid = 1'b1; pix = 8'd0; pix_sof = 1'b1; pix_last = 1'b0; rgb_ready = 1'b1;
    tick();
    drain();
  endtask

  task automatic stream_all();
    rgb_ready = 1'b1;
    for (int p = 0; p < N; p++) begin
      pix_valid = 1'b1; pix = 8'(p); pix_sof = (p == 0); pix_last = (p % 16 == 15);
      tick();
    end
    drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int sent, guard;
    tbl[0] = '{8'd5, 1'b1, 1'b0, 1'b0, 24'h050505};
    tbl[1] = '{8'd3, 1'b0, 1'b0, 1'b1, 24'h030303};
    tbl[2] = '{8'd5, 1'b0, 1'b0, 1'b0, 24'h050505};
    tbl[3] = '{8'd9, 1'b0, 1'b0, 1'b0, 24'h090909};
    tbl[4] = '{8'd5, 1'b1, 1'b0, 1'b0, 24'hFF0000};
    tbl[5] = '{8'd5, 1'b0, 1'b0, 1'b0, 24'hFF0000};
    tbl[6] = '{8'd6, 1'b0, 1'b1, 1'b0, 24'h060606};
    tbl[7] = '{8'd5, 1'b1, 1'b0, 1'b0, 24'hFF0000};

    rst = 1'b1; wr_stb = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0; copy_req = 1'b0;
    pix_valid = 1'b0; pix = '0; pix_last = 1'b0; pix_sof = 1'b0; rgb_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_rgb_valid", rgb_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_swap_pend", swap_pend, 0);
    chk("rst_swap_done", swap_done, 0);
    chk("rst_rgb", {r, g, b}, 0);
    chk("rst_last_sof", {rgb_last, rgb_sof}, 0);
    chk("rst_pix_ready", pix_ready, 1);

    // 1: ramp into shadow, swap at SOF, stream every index at full rate
    fill_shadow(0);
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    lat_chk = 1'b1;
    stream_all();
    chk("t1_queue_empty", expq.size(), 0);

    // 2: mid-frame swap request only takes effect at the next SOF pixel
    fill_shadow(0);
    wr_stb = 1'b1; wr_addr = 8'd5; wr_data = 24'hFF0000; tick(); wr_stb = 1'b0;
    done_cnt = 0;
    use_tbl = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pix_valid = 1'b1; pix = tbl[i].pix; pix_sof = tbl[i].sof; pix_last = tbl[i].last;
      swap_req = tbl[i].swap; tbl_rgb = tbl[i].rgb;
      tick();
    end
    swap_req = 1'b0;
    drain();
    use_tbl = 1'b0; lat_chk = 1'b0;
    chk("t2_swap_done_count", done_cnt, 1);
    chk("t2_queue_empty", expq.size(), 0);

    // 3: random backpressure and bubbles against the scoreboard
    sent = 0; guard = 0; acc = 1'b0; pix_valid = 1'b0;
    while (sent < 1000 && guard < 20000) begin
      if (!pix_valid || acc) begin
        pix_valid = ($urandom_range(0, 4) != 0);
        pix = 8'($urandom); pix_sof = (sent % 64 == 0); pix_last = (sent % 16 == 15);
      end
      rgb_ready = 1'($urandom_range(0, 1));
      swap_req = ($urandom_range(0, 99) == 0);
      tick();
      swap_req = 1'b0;
      guard++;
      if (acc) sent++;
    end
    chk("t3_sent", sent, 1000);
    drain();
    chk("t3_queue_empty", expq.size(), 0);

    // 4: copy active -> shadow, starved by a dense stream, finished by bubbles
    fill_shadow(1);
    swap_now();
    fill_shadow(1);
    copy_req = 1'b1; tick(); copy_req = 1'b0;
    rgb_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      pix_valid = 1'b1; pix = 8'($urandom); pix_sof = 1'b0; pix_last = 1'b0;
      wr_stb = (i < 50); wr_addr = 8'($urandom); wr_data = 24'($urandom);
      tick();
    end
    wr_stb = 1'b0;
    chk("t4_busy_starved", busy, 1);
    guard = 0;
    while (mbusy && guard < 4000) begin
      pix_valid = (guard % 4 != 3); pix = 8'($urandom);
      tick();
      guard++;
    end
    chk("t4_copy_finished", mbusy, 0);
    drain();
    swap_now();
    stream_all();
    chk("t4_queue_empty", expq.size(), 0);

    // 5: reset in the middle of a copy
    if (mact == 1'b0) swap_now();
    fill_shadow(2);
    drain();
    copy_req = 1'b1; tick(); copy_req = 1'b0;
    repeat (99) tick();
    pix_valid = 1'b1; pix = 8'd7; pix_sof = 1'b0; pix_last = 1'b0; tick();
    pix_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_rgb_valid", rgb_valid, 0);
    chk("t5_swap_pend", swap_pend, 0);
    rgb_ready = 1'b1;
    for (int p = 200; p < N; p++) begin
      pix_valid = 1'b1; pix = 8'(p); pix_sof = (p == 200); pix_last = (p == N - 1);
      tick();
    end
    drain();
    chk("t5_queue_empty", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
